// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Holds the repeat-FSM encoding and counter sizing function.
package debounce_pkg;

  localparam int HOLD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } rep_state_t;

  // Ceiling log2, never below 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability filter,
// edge pulses and optional press-and-hold auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 0,
  parameter int REPEAT_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CW = clog2(STABLE_TICKS + 1);
  localparam logic [CW:0] STABLE_LIM = STABLE_TICKS[CW:0];

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          level_q;
  logic          rise_d;
  logic          fall_d;
  logic          rep_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= in;
      s  <= s1;
    end
  end

  always_comb begin
    cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  end

  // Any tick that agrees with the current level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (s != level) begin
        if (cnt_inc == STABLE_LIM) begin
          level <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt_inc[CW-1:0];
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    rise_d = level & ~level_q;
    fall_d = ~level & level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= rise_d;
      fall    <= fall_d;
      press   <= rise_d | rep_pulse;
    end
  end

  if (HOLD_TICKS > 0) begin : g_rep

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM =
      HOLD_TICKS[HOLD_CNT_W-1:0];
    localparam logic [HOLD_CNT_W-1:0] REP_LIM =
      REPEAT_TICKS[HOLD_CNT_W-1:0];

    rep_state_t            state;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [HOLD_CNT_W-1:0] hold_inc;
    logic [HOLD_CNT_W-1:0] lim;

    always_comb begin
      lim       = (state == REPEATING) ? REP_LIM : HOLD_LIM;
      hold_inc  = hold_cnt + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
      rep_pulse = tick & level & (state != IDLE)
                & (hold_inc == lim);
    end

    // IDLE keeps hold_cnt at zero, so the rise cycle never repeats.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            hold_cnt <= '0;
            if (level) state <= HELD;
          end
          HELD, REPEATING: begin
            if (!level) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else if (rep_pulse) begin
              state    <= REPEATING;
              hold_cnt <= '0;
            end else if (tick && hold_cnt != lim) begin
              hold_cnt <= hold_inc;
            end
          end
          default: begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end

  end else begin : g_norep

    always_comb begin
      rep_pulse = 1'b0;
    end

  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer and edge detector on the system clock,
// advanced by a shared single-cycle prescaler tick.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 0,
  parameter int REPEAT_TICKS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press
);

  logic [N_CH-1:0] tick_fan;

  assign tick_fan = {N_CH{tick}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_fan[i]),
      .in   (in[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .press(press[i])
    );
  end

endmodule
